// File: rtl/mjpeg_dec_pkg.sv
// Shared constants for the MJPEG decoder datapath: zig-zag to raster mapping,
// the standard JPEG luma/chroma quantisation tables (zig-zag order) and the
// coefficient saturation limits.
package mjpeg_dec_pkg;

  localparam int DW      = 12;
  localparam int QW      = 8;
  localparam int SAT_MAX = 2047;
  localparam int SAT_MIN = -2048;

  // Raster position of each zig-zag index
  localparam logic [5:0] ZZ2NAT [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10,
    17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34,
    27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36,
    29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46,
    53, 60, 61, 54, 47, 55, 62, 63
  };

  // Luma quantisation steps, zig-zag order
  localparam logic [7:0] Q_Y [64] = '{
     16,  11,  12,  14,  12,  10,  16,  14,
     13,  14,  18,  17,  16,  19,  24,  40,
     26,  24,  22,  22,  24,  49,  35,  37,
     29,  40,  58,  51,  61,  60,  57,  51,
     56,  55,  64,  72,  92,  78,  64,  68,
     87,  69,  55,  56,  80, 109,  81,  87,
     95,  98, 103, 104, 103,  62,  77, 113,
    121, 112, 100, 120,  92, 101, 103,  99
  };

  // Chroma quantisation steps, zig-zag order
  localparam logic [7:0] Q_C [64] = '{
     17,  18,  18,  24,  21,  24,  47,  26,
     26,  47,  99,  66,  56,  66,  99,  99,
     99,  99,  99,  99,  99,  99,  99,  99,
     99,  99,  99,  99,  99,  99,  99,  99,
     99,  99,  99,  99,  99,  99,  99,  99,
     99,  99,  99,  99,  99,  99,  99,  99,
     99,  99,  99,  99,  99,  99,  99,  99,
     99,  99,  99,  99,  99,  99,  99,  99
  };

endpackage

// File: rtl/dezigzag_pingpang.sv
// Two-bank coefficient buffer. The write side fills one bank in raster
// positions while the read side streams the other bank out in raster order.
// A bank becomes readable once its last write has committed; reading a bank
// frees it on the cycle its final address is issued.
module dezigzag_pingpang #(
  parameter int DW = 12
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          blk_done_i,
  input  logic          blk_chroma_i,
  input  logic          wr_en_i,
  input  logic          wr_bank_i,
  input  logic [5:0]    wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          wr_last_i,
  output logic          wr_bank_o,
  output logic          wr_full_o,
  output logic [DW-1:0] coef_data_o,
  output logic          coef_valid_o,
  output logic          coef_last_o,
  output logic          coef_chroma_o
);

  logic [DW-1:0] mem_q [128];

  logic [1:0]    full_q, full_d;
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [5:0]    rd_cnt_q, rd_cnt_d;
  logic [1:0]    chroma_tag_q, chroma_tag_d;

  logic          issue;
  logic          rd_end;

  logic [DW-1:0] rdata_p1_q;
  logic          vld_p1_q;
  logic          last_p1_q;
  logic          chroma_p1_q;

  logic [DW-1:0] coef_data_q;
  logic          coef_valid_q;
  logic          coef_last_q;
  logic          coef_chroma_q;

  // The reader is busy exactly while its current bank is marked full
  assign issue  = full_q[rd_bank_q];
  assign rd_end = issue && (rd_cnt_q == 6'd63);

  // Next-state for bank flags, bank pointers, chroma tags and read address
  always_comb begin
    full_d       = full_q;
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    rd_cnt_d     = rd_cnt_q;
    chroma_tag_d = chroma_tag_q;
    if (clr_i) begin
      full_d    = 2'b00;
      wr_bank_d = 1'b0;
      rd_bank_d = 1'b0;
      rd_cnt_d  = 6'd0;
    end else begin
      if (blk_done_i) begin
        wr_bank_d               = !wr_bank_q;
        chroma_tag_d[wr_bank_q] = blk_chroma_i;
      end
      if (issue) begin
        rd_cnt_d = rd_cnt_q + 6'd1;
        if (rd_end) begin
          full_d[rd_bank_q] = 1'b0;
          rd_bank_d         = !rd_bank_q;
        end
      end
      // Applied after the clear so a same-cycle set on one bank wins
      if (wr_en_i && wr_last_i) begin
        full_d[wr_bank_i] = 1'b1;
      end
    end
  end

  // Control state and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q        <= 2'b00;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      rd_cnt_q      <= 6'd0;
      chroma_tag_q  <= 2'b00;
      vld_p1_q      <= 1'b0;
      last_p1_q     <= 1'b0;
      chroma_p1_q   <= 1'b0;
      coef_data_q   <= '0;
      coef_valid_q  <= 1'b0;
      coef_last_q   <= 1'b0;
      coef_chroma_q <= 1'b0;
    end else begin
      full_q        <= full_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      rd_cnt_q      <= rd_cnt_d;
      chroma_tag_q  <= chroma_tag_d;
      // Stage p1: synchronous RAM read in flight
      vld_p1_q      <= issue && !clr_i;
      last_p1_q     <= rd_end && !clr_i;
      chroma_p1_q   <= chroma_tag_q[rd_bank_q];
      // Stage p2: registered output
      coef_data_q   <= rdata_p1_q;
      coef_valid_q  <= vld_p1_q && !clr_i;
      coef_last_q   <= last_p1_q && !clr_i;
      coef_chroma_q <= chroma_p1_q;
    end
  end

  // Buffer storage: raster-addressed write, synchronous read
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[{wr_bank_i, wr_addr_i}] <= wr_data_i;
    end
    if (issue) begin
      rdata_p1_q <= mem_q[{rd_bank_q, rd_cnt_q}];
    end
  end

  // A bank may never be filled and freed on the same cycle
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(wr_en_i && wr_last_i && rd_end && (wr_bank_i == rd_bank_q)));

  assign wr_bank_o     = wr_bank_q;
  assign wr_full_o     = full_q[wr_bank_q];
  assign coef_data_o   = coef_data_q;
  assign coef_valid_o  = coef_valid_q;
  assign coef_last_o   = coef_last_q;
  assign coef_chroma_o = coef_chroma_q;

endmodule

// File: rtl/dezigzag_dequant.sv
// Decoder dequantiser: takes zig-zag ordered quantised coefficients, scales
// each by its luma or chroma quantisation step with saturation, and hands the
// result to a ping-pong buffer that re-emits each block in raster order.
module dezigzag_dequant #(
  parameter int DW          = 12,
  parameter int QW          = 8,
  parameter int BLK_PER_GRP = 8
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          frame_start,
  input  logic [DW-1:0] zz_data,
  input  logic          zz_valid,
  output logic          zz_ready,
  output logic [DW-1:0] coef_data,
  output logic          coef_valid,
  output logic          coef_last,
  output logic          coef_chroma
);

  import mjpeg_dec_pkg::*;

  localparam logic [2:0]            GRP_LAST = 3'(BLK_PER_GRP - 1);
  localparam logic [2:0]            GRP_HALF = 3'(BLK_PER_GRP / 2);
  localparam logic signed [DW+QW:0] PMAX     = (DW+QW+1)'(SAT_MAX);
  localparam logic signed [DW+QW:0] PMIN     = (DW+QW+1)'(SAT_MIN);

  logic [5:0]              wr_cnt_q, wr_cnt_d;
  logic [2:0]              grp_cnt_q, grp_cnt_d;
  logic                    rdy_en_q;
  logic                    accept;
  logic                    blk_done;
  logic                    chroma_sel;
  logic [QW-1:0]           q_sel;
  logic signed [DW+QW:0]   din_ext;
  logic signed [DW+QW:0]   q_ext;
  logic signed [DW+QW:0]   prod;

  logic                    wr_bank;
  logic                    wr_full;

  logic                    vld_p1_q;
  logic                    last_p1_q;
  logic                    bank_p1_q;
  logic [5:0]              addr_p1_q;
  logic [DW-1:0]           data_p1_q;

  // Clamp a full-precision product into the output sample range
  function automatic logic [DW-1:0] sat_coef(input logic signed [DW+QW:0] v);
    if (v > PMAX) begin
      return PMAX[DW-1:0];
    end else if (v < PMIN) begin
      return PMIN[DW-1:0];
    end
    return v[DW-1:0];
  endfunction

  assign zz_ready   = rdy_en_q && !wr_full;
  assign accept     = zz_valid && zz_ready && !frame_start;
  assign blk_done   = accept && (wr_cnt_q == 6'd63);
  assign chroma_sel = (grp_cnt_q >= GRP_HALF);
  assign q_sel      = chroma_sel ? Q_C[wr_cnt_q] : Q_Y[wr_cnt_q];
  assign din_ext    = {{(QW+1){zz_data[DW-1]}}, zz_data};
  assign q_ext      = {{(DW+1){1'b0}}, q_sel};
  assign prod       = din_ext * q_ext;

  // Beat and block-group counters
  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    grp_cnt_d = grp_cnt_q;
    if (frame_start) begin
      wr_cnt_d  = 6'd0;
      grp_cnt_d = 3'd0;
    end else if (accept) begin
      wr_cnt_d = wr_cnt_q + 6'd1;
      if (wr_cnt_q == 6'd63) begin
        grp_cnt_d = (grp_cnt_q == GRP_LAST) ? 3'd0 : grp_cnt_q + 3'd1;
      end
    end
  end

  // Counter state and the ready enable that holds zz_ready low in reset
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_cnt_q  <= 6'd0;
      grp_cnt_q <= 3'd0;
      rdy_en_q  <= 1'b0;
    end else begin
      wr_cnt_q  <= wr_cnt_d;
      grp_cnt_q <= grp_cnt_d;
      rdy_en_q  <= 1'b1;
    end
  end

  // Stage p1 control: write strobe, last flag and bank of each accepted beat
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vld_p1_q  <= 1'b0;
      last_p1_q <= 1'b0;
      bank_p1_q <= 1'b0;
    end else begin
      vld_p1_q  <= accept;
      last_p1_q <= blk_done;
      bank_p1_q <= wr_bank;
    end
  end

  // Stage p1 data: saturated coefficient and its raster address
  always_ff @(posedge sys_clk) begin
    if (accept) begin
      data_p1_q <= sat_coef(prod);
      addr_p1_q <= ZZ2NAT[wr_cnt_q];
    end
  end

  dezigzag_pingpang #(
    .DW (DW)
  ) u_pingpang (
    .clk_i         (sys_clk),
    .rst_ni        (sys_rst_n),
    .clr_i         (frame_start),
    .blk_done_i    (blk_done),
    .blk_chroma_i  (chroma_sel),
    .wr_en_i       (vld_p1_q),
    .wr_bank_i     (bank_p1_q),
    .wr_addr_i     (addr_p1_q),
    .wr_data_i     (data_p1_q),
    .wr_last_i     (last_p1_q),
    .wr_bank_o     (wr_bank),
    .wr_full_o     (wr_full),
    .coef_data_o   (coef_data),
    .coef_valid_o  (coef_valid),
    .coef_last_o   (coef_last),
    .coef_chroma_o (coef_chroma)
  );

endmodule
